// File: rtl/slice_add_pkg.sv
// slice_add_pkg: shared state type and default sizes for the sequenced adder
package slice_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int WIDTH_DEF = 64;
  localparam int SLICE_DEF = 4;
endpackage

// File: rtl/slice_adder.sv
// slice_adder: combinational SLICE-bit adder with carry in/out
module slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
endmodule

// File: rtl/slice_add_sequencer.sv
// slice_add_sequencer: WIDTH-bit add done one SLICE per cycle with rippled carry register
module slice_add_sequencer
  import slice_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy
);
  localparam int N = WIDTH / SLICE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic carry, co;
  logic [CW-1:0] cnt;
  logic [SLICE-1:0] sum;
  logic [WIDTH+SLICE-1:0] s_next;
  slice_adder #(.SLICE(SLICE)) u_add (
    .a(a_r[SLICE-1:0]), .b(b_r[SLICE-1:0]), .ci(carry), .s(sum), .co(co)
  );
  // new slice enters at the top so the low slice ends up at bit 0 after N steps
  assign s_next = {sum, S} >> SLICE;
  assign in_ready = state == IDLE && !rst;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      S <= '0;
      Cout <= 1'b0;
      carry <= 1'b0;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= A;
          b_r <= B;
          carry <= Cin;
          cnt <= '0;
          S <= '0;
          state <= RUN;
        end
        RUN: begin
          a_r <= a_r >> SLICE;
          b_r <= b_r >> SLICE;
          S <= s_next[WIDTH-1:0];
          carry <= co;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            out_valid <= 1'b1;
            Cout <= co;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_slice_add_sequencer.sv
// tb_slice_add_sequencer: directed and random checks of the sequenced adder
module tb_slice_add_sequencer;
  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 1, Cin = 0;
  logic [63:0] A = '0, B = '0;
  logic in_ready, out_valid, Cout, busy;
  logic [63:0] S;
  logic in_valid8 = 0, out_ready8 = 1, cin8 = 0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic in_ready8, out_valid8, cout8, busy8;
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  slice_add_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .Cout(Cout), .busy(busy)
  );

  slice_add_sequencer #(.WIDTH(8), .SLICE(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .A(a8), .B(b8), .Cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8), .S(s8), .Cout(cout8), .busy(busy8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accepts one operand set and waits for the result; out_ready=1 consumes it on the next edge
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                        output int lat, output logic [63:0] s, output logic co);
    A = a; B = b; Cin = c; in_valid = 1;
    tick();
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    s = S; co = Cout;
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    vecs++; if ({out_valid, Cout, busy, in_ready} !== 4'b0000) begin errs++; $display("FAIL reset_ctl got %b want 0000", {out_valid, Cout, busy, in_ready}); end
    vecs++; if (S !== 64'h0) begin errs++; $display("FAIL reset_s got %h want 0", S); end
    rst = 0;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_carry_all();
    int lat; logic [63:0] s; logic co;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, lat, s, co);
    vecs++; if (s !== 64'h0) begin errs++; $display("FAIL carry_s got %h want 0", s); end
    vecs++; if (co !== 1'b1) begin errs++; $display("FAIL carry_cout got %b want 1", co); end
    vecs++; if (lat !== 16) begin errs++; $display("FAIL carry_latency got %0d want 16", lat); end
    vecs++; if ({out_valid, in_ready, busy} !== 3'b010) begin errs++; $display("FAIL carry_consume got %b want 010", {out_valid, in_ready, busy}); end
  endtask

  task automatic test_no_carry();
    int lat; logic [63:0] s; logic co;
    run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, lat, s, co);
    vecs++; if (s !== 64'hFFFF_FFFF_FFFF_FFFF) begin errs++; $display("FAIL nocarry_s got %h want ffffffffffffffff", s); end
    vecs++; if (co !== 1'b0) begin errs++; $display("FAIL nocarry_cout got %b want 0", co); end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 0;
    A = 64'h8000_0000_0000_0001; B = 64'h8000_0000_0000_0002; Cin = 1; in_valid = 1;
    tick();
    A = 64'h0000_0000_0000_0064; B = 64'h0000_0000_0000_00C8; Cin = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    vecs++; if (lat !== 16) begin errs++; $display("FAIL bp_latency got %0d want 16", lat); end
    for (int i = 0; i < 5; i++) begin
      vecs++; if ({Cout, S} !== {1'b1, 64'h0000_0000_0000_0004}) begin errs++; $display("FAIL bp_hold%0d got %b_%h want 1_0000000000000004", i, Cout, S); end
      vecs++; if ({out_valid, in_ready, busy} !== 3'b101) begin errs++; $display("FAIL bp_ctl%0d got %b want 101", i, {out_valid, in_ready, busy}); end
      tick();
    end
    out_ready = 1;
    tick();
    vecs++; if ({out_valid, in_ready} !== 2'b01) begin errs++; $display("FAIL bp_release got %b want 01", {out_valid, in_ready}); end
    tick();
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    vecs++; if ({Cout, S} !== {1'b0, 64'h0000_0000_0000_012C}) begin errs++; $display("FAIL bp_second got %b_%h want 0_000000000000012c", Cout, S); end
    vecs++; if (lat !== 16) begin errs++; $display("FAIL bp_second_latency got %0d want 16", lat); end
    tick();
  endtask

  task automatic test_mid_reset();
    int lat; logic [63:0] s; logic co;
    A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'hFFFF_FFFF_FFFF_FFFF; Cin = 1; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (6) tick();
    rst = 1;
    tick();
    vecs++; if ({out_valid, Cout, busy} !== 3'b000) begin errs++; $display("FAIL mrst_ctl got %b want 000", {out_valid, Cout, busy}); end
    vecs++; if (S !== 64'h0) begin errs++; $display("FAIL mrst_s got %h want 0", S); end
    rst = 0;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL mrst_in_ready got %b want 1", in_ready); end
    run_op(64'd5, 64'd7, 1'b1, lat, s, co);
    vecs++; if ({co, s} !== {1'b0, 64'd13}) begin errs++; $display("FAIL mrst_next got %b_%h want 0_000000000000000d", co, s); end
  endtask

  task automatic test_back_to_back();
    logic [64:0] exp_q[$];
    logic [64:0] e;
    int sent = 0, got = 0, cyc = 0, last = -1;
    out_ready = 1;
    in_valid = 0;
    while (got < 1000 && cyc < 20000) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        vecs++; if ({Cout, S} !== e) begin errs++; $display("FAIL b2b_result%0d got %b_%h want %b_%h", got, Cout, S, e[64], e[63:0]); end
        if (last >= 0) begin
          vecs++; if (cyc - last !== 18) begin errs++; $display("FAIL b2b_interval%0d got %0d want 18", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
      if (in_ready) begin
        if (sent < 1000) begin
          A = {$urandom, $urandom}; B = {$urandom, $urandom}; Cin = 1'($urandom);
          exp_q.push_back({1'b0, A} + {1'b0, B} + {64'h0, Cin});
          in_valid = 1;
          sent++;
        end else in_valid = 0;
      end
      tick();
      cyc++;
    end
    in_valid = 0;
    vecs++; if (got !== 1000) begin errs++; $display("FAIL b2b_count got %0d want 1000", got); end
    repeat (20) tick();
  endtask

  task automatic test_param_sweep();
    int lat;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 0; in_valid8 = 1; out_ready8 = 0;
    tick();
    in_valid8 = 0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin tick(); lat++; end
    vecs++; if (lat !== 2) begin errs++; $display("FAIL sweep_latency got %0d want 2", lat); end
    vecs++; if ({cout8, s8} !== 9'h100) begin errs++; $display("FAIL sweep_result got %b_%h want 1_00", cout8, s8); end
    out_ready8 = 1;
    tick();
    vecs++; if ({out_valid8, in_ready8} !== 2'b01) begin errs++; $display("FAIL sweep_consume got %b want 01", {out_valid8, in_ready8}); end
  endtask

  initial begin
    test_reset();
    test_carry_all();
    test_no_carry();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/slice_add_sequencer.md
# slice_add_sequencer

Multi-cycle 64-bit adder controller. It accepts A, B and Cin through a valid/ready handshake and sequences a narrow SLICE-bit adder over WIDTH/SLICE cycles, rippling carry through a register. It returns {Cout, S} equal to A + B + Cin through an output valid/ready handshake. It sits in front of the lab's adder datapath as the area-reduced, sequenced alternative to the single-cycle 64-bit add.

## Interface
- WIDTH, 64, operand/sum width; must be an integer multiple of SLICE
- SLICE, 4, adder slice width per cycle; N = WIDTH/SLICE slice steps
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept; high only in IDLE and while rst is low
- A  input  WIDTH  operand A, sampled on accept
- B  input  WIDTH  operand B, sampled on accept
- Cin  input  1  carry-in, sampled on accept
- out_valid  output  1  result valid; held until consumed
- out_ready  input  1  consumer accepts result
- S  output  WIDTH  sum
- Cout  output  1  carry-out of bit WIDTH-1
- busy  output  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready: load A, B into shift registers, load Cin into the carry register, clear the slice counter, clear S, go to RUN.
- RUN, each cycle:
  - The slice adder adds the low SLICE bits of the A/B registers plus carry.
  - A/B shift right by SLICE.
  - The slice sum shifts into the top SLICE bits of S (S shifts right by SLICE).
  - The carry register takes the slice carry-out.
  - The counter increments.
  - On the step with counter == N-1: go to DONE, set out_valid, copy the final carry to Cout.
- DONE:
  - out_valid=1; S and Cout are stable.
  - On out_ready: out_valid drops next cycle and the FSM returns to IDLE.
  - in_valid is ignored while in DONE.
- Arithmetic: the result is exactly A + B + Cin modulo 2^WIDTH, and Cout is bit WIDTH of the full sum. No overflow/signed interpretation.
- Operands are captured at accept. Input changes after accept have no effect.
- Counter width is clog2(N), minimum 1. The counter never wraps mid-operation; it is cleared on accept.
- Reset (any state, including mid-RUN or DONE):
  - Next state IDLE.
  - out_valid=0, S=0, Cout=0, busy=0, carry and counter cleared.
  - The partial result is discarded and never presented.
- in_ready is forced 0 while rst=1.

## Timing
- Accept edge = edge t. RUN steps occur at edges t+1 … t+N. out_valid is high from edge t+N (N=16 at defaults).
- With out_ready held high, out_valid is high for exactly one cycle. IDLE is re-entered at edge t+N+1, and the next accept can occur at edge t+N+2.
- Throughput: one result per N+2 cycles with no backpressure.
- Outputs are registered. in_ready and busy are decoded from the state register with no combinational path from in_valid or out_ready.
- Reset values: in_ready=1 (after rst deasserts), out_valid=0, S=0, Cout=0, busy=0.

## Structure
- Shared package slice_add_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - default constants for WIDTH and SLICE.
- One sub-module, slice_adder: purely combinational, parameter SLICE, computes {co, s} = a + b + ci.
- The controller holds the FSM, counter, operand shift registers, carry register and result register.

## Test plan
- Carry through all slices: A=0xFFFF_FFFF_FFFF_FFFF, B=0, Cin=1 -> S=0x0, Cout=1; out_valid first high exactly 16 edges after the accept edge.
- No carry: A=0x0123_4567_89AB_CDEF, B=0xFEDC_BA98_7654_3210, Cin=0 -> S=0xFFFF_FFFF_FFFF_FFFF, Cout=0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid rises; in_valid=1 with new operands throughout.
  - Required: S, Cout and out_valid stay stable, in_ready=0, and the new operands are not accepted until IDLE.
- Mid-operation reset:
  - Stimulus: rst pulsed for 1 cycle at RUN step 7.
  - Required: out_valid, S, Cout and busy all 0 after that edge, and in_ready=1 the following cycle. The next operation, A=5, B=7, Cin=1, yields S=13, Cout=0.
- Back-to-back random:
  - Stimulus: in_valid and out_ready tied high, 1000 random operand sets.
  - Required: every result matches the behavioral A + B + Cin model, and results arrive every 18 cycles.
- Parameter sweep: WIDTH=8, SLICE=4, A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1, with out_valid 2 edges after accept.
